// File: rtl/frame_buffer_double_if.sv
// Pixel-writer / scan-out bus of the double-buffered frame store.
// The master side is the writer plus video timing; the slave side is the frame store.
interface frame_buffer_double_if #(
  parameter int unsigned ADDR_WIDTH = 19
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_data;
  logic                  frame_end;
  logic                  swap;
  logic                  front_sel;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_end,
    input  rd_data, swap, front_sel
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_end,
    output rd_data, swap, front_sel
  );
endinterface

// File: rtl/frame_buffer_double.sv
// Double-buffered 1-bpp frame store: the writer fills the back bank while scan-out reads the
// front bank; the banks exchange at a frame boundary once the back bank has been completed.
module frame_buffer_double #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  localparam int unsigned PIXELS     = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
  localparam int unsigned ADDR_WIDTH = $clog2(PIXELS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  frame_buffer_double_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   PixelsExt = (ADDR_WIDTH + 1)'(PIXELS);

  logic r_bank0 [PIXELS];
  logic r_bank1 [PIXELS];

  logic r_front_sel;
  logic r_swap;
  logic r_back_ready;
  logic r_rd_data;

  logic w_wr_ok;
  logic w_rd_ok;
  logic w_rd_bit;
  logic w_last_write;
  logic w_flip;

  // Range checks are widened by one bit so PIXELS itself is representable.
  assign w_wr_ok      = bus.wr_en && ({1'b0, bus.wr_addr} < PixelsExt);
  assign w_rd_ok      = {1'b0, bus.rd_addr} < PixelsExt;
  assign w_rd_bit     = r_front_sel ? r_bank1[bus.rd_addr] : r_bank0[bus.rd_addr];
  assign w_last_write = bus.wr_en && (bus.wr_addr == LastAddr);
  assign w_flip       = bus.frame_end && (r_back_ready || w_last_write);

  // Memory is not reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_ce && w_wr_ok) begin
      if (r_front_sel) begin
        r_bank0[bus.wr_addr] <= bus.wr_data;
      end else begin
        r_bank1[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= 1'b0;
    end else if (i_ce && bus.rd_en) begin
      r_rd_data <= w_rd_ok & w_rd_bit;
    end
  end

  // A final write coinciding with frame_end lands in the old back bank, which is the one being
  // promoted on that same edge, so the flip is allowed without losing the frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_front_sel  <= 1'b0;
      r_swap       <= 1'b0;
      r_back_ready <= 1'b0;
    end else if (i_ce) begin
      if (w_flip) begin
        r_front_sel  <= ~r_front_sel;
        r_swap       <= 1'b1;
        r_back_ready <= 1'b0;
      end else begin
        r_swap <= 1'b0;
        if (w_last_write) begin
          r_back_ready <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.swap      = r_swap;
  assign bus.front_sel = r_front_sel;

endmodule

// File: tb/tb_frame_buffer_double.sv
// Bench for frame_buffer_double on a 6x4 frame: read results are checked through a scoreboard,
// bank-exchange behaviour through hand-written sequences.
module tb_frame_buffer_double;

  localparam int unsigned H   = 6;
  localparam int unsigned V   = 4;
  localparam int unsigned PIX = H * V;
  localparam int unsigned AW  = $clog2(PIX);

  logic clk = 1'b0;
  logic rst;
  logic ce;

  always #5 clk = ~clk;

  frame_buffer_double_if #(.ADDR_WIDTH(AW)) bus ();

  frame_buffer_double #(
    .HOR_ACTIVE_PIXELS(H),
    .VER_ACTIVE_PIXELS(V)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_ce (ce),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          exp;
  } rd_vec_t;

  int   total = 0;
  int   bad   = 0;
  logic sb_q[$];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic checker_px(input int a);
    return logic'(((a % H) + (a / H)) & 1);
  endfunction

  task automatic issue_read(input int a, input logic exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(a);
    sb_q.push_back(exp);
  endtask

  // One clock; a read issued this cycle is popped and compared after the edge.
  task automatic tick();
    bit   issued;
    logic exp;
    issued = bus.rd_en && ce && !rst;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    if (issued) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        exp = sb_q.pop_front();
        check("rd_data", bus.rd_data, exp);
      end
    end
  endtask

  task automatic write(input int a, input logic d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_frame_end();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rd_vec_t vec[6];
    vec[0] = '{addr: AW'(0),   exp: 1'b0};
    vec[1] = '{addr: AW'(1),   exp: 1'b1};
    vec[2] = '{addr: AW'(H),   exp: 1'b1};
    vec[3] = '{addr: AW'(7),   exp: 1'b0};
    vec[4] = '{addr: AW'(23),  exp: 1'b0};
    vec[5] = '{addr: AW'(PIX), exp: 1'b0};

    rst = 1'b1;
    ce  = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.frame_end = 1'b0;
    tick();
    tick();
    check("rst_front_sel", bus.front_sel, 1'b0);
    check("rst_swap", bus.swap, 1'b0);
    check("rst_rd_data", bus.rd_data, 1'b0);
    rst = 1'b0;

    // Checkerboard into bank1, then exchange.
    for (int a = 0; a < PIX; a++) write(a, checker_px(a));
    check("fill_no_swap", bus.swap, 1'b0);
    check("fill_front", bus.front_sel, 1'b0);
    pulse_frame_end();
    check("t1_swap", bus.swap, 1'b1);
    check("t1_front", bus.front_sel, 1'b1);
    tick();
    check("t1_swap_clear", bus.swap, 1'b0);
    for (int i = 0; i < 6; i++) begin
      issue_read(int'(vec[i].addr), vec[i].exp);
      tick();
    end

    // frame_end before back bank is complete: repeat the frame.
    for (int a = 0; a < PIX - 1; a++) write(a, ~checker_px(a));
    pulse_frame_end();
    check("t2_early_swap", bus.swap, 1'b0);
    check("t2_early_front", bus.front_sel, 1'b1);
    issue_read(0, 1'b0);
    tick();
    write(PIX - 1, ~checker_px(PIX - 1));
    pulse_frame_end();
    check("t2_swap", bus.swap, 1'b1);
    check("t2_front", bus.front_sel, 1'b0);
    issue_read(0, 1'b1);
    tick();
    issue_read(PIX - 1, 1'b1);
    tick();

    // Last write, frame_end and a read on one edge; the read still sees the old front.
    for (int a = 0; a < PIX - 1; a++) write(a, 1'b1);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(PIX - 1); bus.wr_data = 1'b1;
    bus.frame_end = 1'b1;
    issue_read(1, 1'b0);
    tick();
    bus.wr_en = 1'b0; bus.frame_end = 1'b0;
    check("t3_swap", bus.swap, 1'b1);
    check("t3_front", bus.front_sel, 1'b1);
    issue_read(PIX - 1, 1'b1);
    tick();
    issue_read(1, 1'b1);
    tick();

    // Swap held through ce=0; writes and frame_end ignored while ce=0.
    for (int a = 0; a < PIX; a++) write(a, 1'b1);
    pulse_frame_end();
    check("t4_swap", bus.swap, 1'b1);
    check("t4_front", bus.front_sel, 1'b0);
    ce = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = AW'(PIX - 1); bus.wr_data = 1'b0;
    bus.frame_end = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_swap_hold", bus.swap, 1'b1);
      check("t4_front_hold", bus.front_sel, 1'b0);
    end
    ce = 1'b1;
    bus.wr_en = 1'b0; bus.frame_end = 1'b0;
    tick();
    check("t4_swap_drop", bus.swap, 1'b0);
    pulse_frame_end();
    check("t4_no_flip", bus.swap, 1'b0);
    check("t4_no_flip_front", bus.front_sel, 1'b0);
    issue_read(0, 1'b1);
    tick();

    // Reset with back_ready pending.
    write(PIX - 1, 1'b0);
    rst = 1'b1;
    bus.frame_end = 1'b1;
    tick();
    check("t5_front", bus.front_sel, 1'b0);
    check("t5_swap", bus.swap, 1'b0);
    check("t5_rd_data", bus.rd_data, 1'b0);
    rst = 1'b0;
    tick();
    bus.frame_end = 1'b0;
    check("t5_no_flip", bus.swap, 1'b0);
    check("t5_no_flip_front", bus.front_sel, 1'b0);

    // Out-of-range addresses.
    issue_read(0, 1'b1);
    tick();
    write(PIX, 1'b0);
    issue_read(PIX, 1'b0);
    tick();
    pulse_frame_end();
    check("t6_no_flip", bus.swap, 1'b0);
    issue_read(0, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
